// File: rtl/seq_mul_ctrl.sv
// Operand sequencer and result collector for the 8x8 sequential shift-add multiplier.
// Drives enable/A/B through load and iteration windows, captures the product, keeps a running sum.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// LOAD  | multiplier loads B and clears its product/counter (enable low)
// RUN   | multiplier iterates, enable high for MUL_CYCLES cycles
// CAPT  | final product on mul_c, captured and accumulated at the closing edge
// DONE  | result presented downstream until accepted
module seq_mul_ctrl #(
   parameter int MUL_CYCLES = 8,
   parameter int ACC_W      = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_a,
   input  logic [7:0]       in_b,
   input  logic             in_acc_clr,
   output logic             mul_enable,
   output logic [7:0]       mul_a,
   output logic [7:0]       mul_b,
   input  logic [15:0]      mul_c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_prod,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_acc_ovf
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_CAPT,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             clr_q;
   logic [ACC_W:0]   acc_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (in_valid) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_RUN;
         S_RUN:  if (cnt == CNT_LAST) state_nxt = S_CAPT;
         S_CAPT: state_nxt = S_DONE;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign in_ready   = (state == S_IDLE);
   assign out_valid  = (state == S_DONE);
   assign mul_enable = (state == S_RUN);

   // carry out of the top bit feeds the sticky wrap flag
   assign acc_sum = {1'b0, (clr_q ? {ACC_W{1'b0}} : out_acc)} + (ACC_W + 1)'(mul_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         clr_q       <= 1'b0;
         out_prod    <= '0;
         out_acc     <= '0;
         out_acc_ovf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  mul_a <= in_a;
                  mul_b <= in_b;
                  clr_q <= in_acc_clr;
               end
            end
            S_LOAD: cnt <= '0;
            S_RUN:  cnt <= cnt + CNT_W'(1);
            S_CAPT: begin
               out_prod    <= mul_c;
               out_acc     <= acc_sum[ACC_W-1:0];
               out_acc_ovf <= (clr_q ? 1'b0 : out_acc_ovf) | acc_sum[ACC_W];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench for seq_mul_ctrl: behavioural shift-add multipliers behind two instances (ACC_W=24 and 16),
// a vector table driven through a scoreboard, and hand sequences for backpressure and mid-op reset.
module tb_seq_mul_ctrl;

   localparam int MUL_CYCLES = 8;

   logic        clk, rst_n;
   logic        in_valid, in_acc_clr, out_ready;
   logic [7:0]  in_a, in_b;

   logic        in_ready, out_valid, mul_enable, out_acc_ovf;
   logic [7:0]  mul_a, mul_b;
   logic [15:0] mul_c, out_prod;
   logic [23:0] out_acc;

   logic        in_ready2, out_valid2, mul_enable2, out_acc_ovf2;
   logic [7:0]  mul_a2, mul_b2;
   logic [15:0] mul_c2, out_prod2, out_acc2;

   seq_mul_ctrl #(.MUL_CYCLES(MUL_CYCLES), .ACC_W(24)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_acc_clr(in_acc_clr),
      .mul_enable(mul_enable), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
      .out_acc(out_acc), .out_acc_ovf(out_acc_ovf)
   );

   seq_mul_ctrl #(.MUL_CYCLES(MUL_CYCLES), .ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b), .in_acc_clr(in_acc_clr),
      .mul_enable(mul_enable2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_c(mul_c2),
      .out_valid(out_valid2), .out_ready(out_ready), .out_prod(out_prod2),
      .out_acc(out_acc2), .out_acc_ovf(out_acc_ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // shift-add multiplier models: enable low loads B and clears, each enabled edge handles one bit
   logic [15:0] mp1, mp2;
   logic [7:0]  mm1, mm2;
   logic [3:0]  mc1, mc2;

   always @(posedge clk) begin
      if (!mul_enable) begin
         mp1 <= 16'h0; mm1 <= mul_b; mc1 <= 4'd0;
      end else if (mc1 < 4'd8) begin
         if (mm1[mc1[2:0]]) mp1 <= mp1 + (16'(mul_a) << mc1);
         mc1 <= mc1 + 4'd1;
      end
   end

   always @(posedge clk) begin
      if (!mul_enable2) begin
         mp2 <= 16'h0; mm2 <= mul_b2; mc2 <= 4'd0;
      end else if (mc2 < 4'd8) begin
         if (mm2[mc2[2:0]]) mp2 <= mp2 + (16'(mul_a2) << mc2);
         mc2 <= mc2 + 4'd1;
      end
   end

   assign mul_c  = mp1;
   assign mul_c2 = mp2;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        clr;
      logic [15:0] prod;
   } vec_t;

   typedef struct {
      logic [15:0] prod;
      logic [23:0] acc;
      logic        ovf;
      logic [15:0] acc16;
      logic        ovf16;
   } exp_t;

   exp_t        sb[$];
   logic [23:0] acc_m;
   logic        ovf_m;
   logic [15:0] acc16_m;
   logic        ovf16_m;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   task automatic push_exp(input vec_t v);
      logic [24:0] s24;
      logic [16:0] s16;
      exp_t e;
      s24     = {1'b0, (v.clr ? 24'h0 : acc_m)} + 25'(v.prod);
      s16     = {1'b0, (v.clr ? 16'h0 : acc16_m)} + 17'(v.prod);
      acc_m   = s24[23:0];
      ovf_m   = (v.clr ? 1'b0 : ovf_m) | s24[24];
      acc16_m = s16[15:0];
      ovf16_m = (v.clr ? 1'b0 : ovf16_m) | s16[16];
      e.prod = v.prod; e.acc = acc_m; e.ovf = ovf_m; e.acc16 = acc16_m; e.ovf16 = ovf16_m;
      sb.push_back(e);
   endtask

   // call just after a posedge; returns at the negedge of the LOAD cycle
   task automatic start_op(input vec_t v);
      int w;
      @(negedge clk);
      in_valid = 1'b1; in_a = v.a; in_b = v.b; in_acc_clr = v.clr;
      w = 0;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      push_exp(v);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // starts at the LOAD negedge; returns at the first negedge with out_valid high
   task automatic wait_result(input vec_t v);
      int   k;
      logic en_ok, op_ok;
      exp_t e;
      k = 0; en_ok = 1'b1; op_ok = 1'b1;
      while (!out_valid && k < 40) begin
         if (mul_enable !== ((k >= 1) && (k <= MUL_CYCLES))) en_ok = 1'b0;
         if (mul_a !== v.a || mul_b !== v.b || in_ready !== 1'b0) op_ok = 1'b0;
         @(negedge clk);
         k++;
      end
      chk("latency", 32'(k), 32'(MUL_CYCLES + 2));
      chk("enable_wave", 32'(en_ok), 32'd1);
      chk("operand_hold", 32'(op_ok), 32'd1);
      if (out_valid && sb.size() > 0) begin
         e = sb.pop_front();
         chk("out_prod", 32'(out_prod), 32'(e.prod));
         chk("out_acc", 32'(out_acc), 32'(e.acc));
         chk("out_acc_ovf", 32'(out_acc_ovf), 32'(e.ovf));
         chk("out_prod16", 32'(out_prod2), 32'(e.prod));
         chk("out_acc16", 32'(out_acc2), 32'(e.acc16));
         chk("out_acc_ovf16", 32'(out_acc_ovf2), 32'(e.ovf16));
      end else begin
         chk("result_missing", 32'(out_valid), 32'd1);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_mul_enable"}, 32'(mul_enable), 32'd0);
      chk({tag, "_mul_ab"}, 32'({mul_a, mul_b}), 32'd0);
      chk({tag, "_out_prod"}, 32'(out_prod), 32'd0);
      chk({tag, "_out_acc"}, 32'(out_acc), 32'd0);
      chk({tag, "_ovf"}, 32'(out_acc_ovf), 32'd0);
      chk({tag, "_acc16"}, 32'(out_acc2), 32'd0);
   endtask

   vec_t vecs[8];
   vec_t v_bp1, v_bp2, v_rst;
   logic [15:0] prod_hold;
   logic [23:0] acc_hold;
   logic        hold_ok;

   initial begin
      vecs[0] = '{a: 8'd13,  b: 8'd11,  clr: 1'b1, prod: 16'h008F};
      vecs[1] = '{a: 8'd255, b: 8'd255, clr: 1'b1, prod: 16'hFE01};
      vecs[2] = '{a: 8'd255, b: 8'd255, clr: 1'b0, prod: 16'hFE01};
      vecs[3] = '{a: 8'd1,   b: 8'd1,   clr: 1'b1, prod: 16'h0001};
      vecs[4] = '{a: 8'd0,   b: 8'd200, clr: 1'b0, prod: 16'h0000};
      vecs[5] = '{a: 8'd77,  b: 8'd0,   clr: 1'b0, prod: 16'h0000};
      vecs[6] = '{a: 8'd200, b: 8'd3,   clr: 1'b0, prod: 16'h0258};
      vecs[7] = '{a: 8'd100, b: 8'd100, clr: 1'b0, prod: 16'h2710};
      v_bp1   = '{a: 8'd5,   b: 8'd6,   clr: 1'b1, prod: 16'd30};
      v_bp2   = '{a: 8'd9,   b: 8'd10,  clr: 1'b0, prod: 16'd90};
      v_rst   = '{a: 8'd7,   b: 8'd9,   clr: 1'b1, prod: 16'd63};
      acc_m = '0; ovf_m = 1'b0; acc16_m = '0; ovf16_m = 1'b0;

      rst_n = 1'b0; in_valid = 1'b0; in_a = 8'h0; in_b = 8'h0; in_acc_clr = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(posedge clk);

      // back-to-back table ops, out_ready held high the whole time
      for (int i = 0; i < 8; i++) begin
         start_op(vecs[i]);
         wait_result(vecs[i]);
         @(posedge clk);
      end
      @(negedge clk);
      chk("handshake_clear", 32'(out_valid), 32'd0);
      @(posedge clk);

      // backpressure with a new operand pending
      out_ready = 1'b0;
      start_op(v_bp1);
      wait_result(v_bp1);
      in_valid = 1'b1; in_a = v_bp2.a; in_b = v_bp2.b; in_acc_clr = v_bp2.clr;
      prod_hold = out_prod; acc_hold = out_acc; hold_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_prod !== prod_hold ||
             out_acc !== acc_hold || mul_enable !== 1'b0) hold_ok = 1'b0;
      end
      chk("bp_hold", 32'(hold_ok), 32'd1);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_idle_ready", 32'(in_ready), 32'd1);
      chk("bp_one_handshake", 32'(out_valid), 32'd0);
      @(posedge clk);
      push_exp(v_bp2);
      @(negedge clk);
      in_valid = 1'b0;
      wait_result(v_bp2);
      @(posedge clk);

      // reset during the fourth RUN cycle of 7x9
      start_op(v_rst);
      repeat (4) @(negedge clk);
      chk("rst_pre_enable", 32'(mul_enable), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      void'(sb.pop_back());
      acc_m = '0; ovf_m = 1'b0; acc16_m = '0; ovf16_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      start_op(v_rst);
      wait_result(v_rst);
      @(posedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
